// File: rtl/change_logger_pkg.sv
// Shared definitions for the change logger: frame header byte,
// bytes-per-width helper and serializer state encoding.
package trace_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LOAD,
        SER_SEND
    } ser_state_t;

    function automatic int bytes_for(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/change_logger_if.sv
// Byte handshake between the record serializer and the UART.
// Signals: data (byte), valid (master), ready (slave).
interface change_logger_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/change_logger_uart_tx.sv
// UART 8N1 transmitter, DIV clocks per bit, back-to-back capable.
// Ports: i_clk, i_rst_n (async low), s_byte (slave), o_txd, o_busy.
module uart_tx #(
    parameter int DIV = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    change_logger_if.slave  s_byte,
    output logic            o_txd,
    output logic            o_busy
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_busy;
    logic          r_txd;
    logic          w_bit_end;
    logic          w_last;

    assign w_bit_end = (r_cnt == CW'(DIV - 1));
    // Ready in the final cycle of the stop bit so bytes abut.
    assign w_last = r_busy && (r_bit == 4'd9) && w_bit_end;
    assign s_byte.ready = !r_busy || w_last;
    assign o_txd = r_txd;
    assign o_busy = r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_data <= '0;
            r_busy <= 1'b0;
            r_txd  <= 1'b1;
        end else if (s_byte.valid && s_byte.ready) begin
            r_data <= s_byte.data;
            r_busy <= 1'b1;
            r_bit  <= '0;
            r_cnt  <= '0;
            r_txd  <= 1'b0;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    r_txd  <= 1'b1;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    // bit index b+1 carries data[b]; index 9 is stop
                    r_txd <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/change_logger.sv
// Logs every change of PROBE as {timestamp, value} into a FIFO and
// streams frames (A5, ts bytes, value bytes, MSB-first) over UART.
// Ports: CLK, RESET (async low), PROBE, TXD, OVERFLOW, BUSY.
// Macro CHANGE_LOGGER_TIMESTAMP_EN enables the timestamp counter.
module change_logger
    import trace_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int TS_WIDTH    = 16,
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD        = 115200
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PROBE,
    output logic             TXD,
    output logic             OVERFLOW,
    output logic             BUSY
);
    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int NVB   = bytes_for(WIDTH);
    localparam int VW    = NVB * 8;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    localparam int NTB   = TS_WIDTH / 8;
`else
    localparam int NTB   = 0;
`endif
    localparam int REC_W = NTB * 8 + VW;
    localparam int NB    = 1 + NTB + NVB;
    localparam int FW    = NB * 8;
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_p;
    logic [REC_W-1:0] w_rec;
    logic             w_push;

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;
    logic             r_ovf;

    ser_state_t       r_state;
    logic [REC_W-1:0] r_rec;
    logic [3:0]       r_k;
    logic [3:0]       w_nk;
    logic [7:0]       r_byte;
    logic             r_valid;
    logic [FW-1:0]    w_frame;
    logic [FW-1:0]    w_shift;
    logic             w_tx_busy;

    change_logger_if u_bus ();

    assign w_push = (r_s != r_p);

`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_ts <= '0;
        else        r_ts <= r_ts + TS_WIDTH'(1);
    end

    assign w_rec = {r_ts, VW'(r_s)};
`else
    assign w_rec = VW'(r_s);
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_s <= '0;
            r_p <= '0;
        end else begin
            r_s <= PROBE;
            if (w_push) r_p <= r_s;
        end
    end

    // Fullness is judged before any same-cycle pop.
    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_wr    = w_push && !w_full;
    assign w_rd    = (r_state == SER_IDLE) && !w_empty;

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr] <= w_rec;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) r_wr <= r_wr + AW'(1);
            if (w_rd) r_rd <= r_rd + AW'(1);
            if (w_wr && !w_rd)      r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_wr && w_rd) r_cnt <= r_cnt - CNT_W'(1);
            if (w_push && w_full) r_ovf <= 1'b1;
        end
    end

    // Byte k of the frame is the k-th byte from the top of w_frame.
    assign w_frame = {FRAME_HDR, r_rec};
    assign w_nk    = r_k + 4'd1;
    assign w_shift = w_frame << {w_nk, 3'b000};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= SER_IDLE;
            r_rec   <= '0;
            r_k     <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                SER_IDLE: begin
                    if (!w_empty) begin
                        r_rec   <= r_mem[r_rd];
                        r_byte  <= FRAME_HDR;
                        r_valid <= 1'b1;
                        r_k     <= '0;
                        r_state <= SER_LOAD;
                    end
                end
                SER_LOAD: begin
                    if (u_bus.ready) begin
                        r_byte  <= w_shift[FW-1 -: 8];
                        r_k     <= w_nk;
                        r_state <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (u_bus.ready) begin
                        if (r_k == 4'(NB - 1)) begin
                            r_valid <= 1'b0;
                            r_state <= SER_IDLE;
                        end else begin
                            r_byte <= w_shift[FW-1 -: 8];
                            r_k    <= w_nk;
                        end
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    assign u_bus.data  = r_byte;
    assign u_bus.valid = r_valid;

    uart_tx #(
        .DIV (DIV)
    ) u_uart_tx (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .s_byte  (u_bus.slave),
        .o_txd   (TXD),
        .o_busy  (w_tx_busy)
    );

    assign OVERFLOW = r_ovf;
    assign BUSY     = !w_empty || (r_state != SER_IDLE) || w_tx_busy;

endmodule

// File: doc/change_logger.md
CHANGE_LOGGER -- requirements
Module: change_logger

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the monitored bus, 1..32.
REQ-002 The block SHALL have parameter DEPTH, default 16: record FIFO entries, power of two, 2..256.
REQ-003 The block SHALL have parameter TS_WIDTH, default 16: timestamp width, a multiple of 8, 8..32.
REQ-004 The block SHALL have parameter CLK_FREQ_HZ, default 10000000: CLK frequency.
REQ-005 The block SHALL have parameter BAUD, default 115200: UART bit rate; DIV = CLK_FREQ_HZ/BAUD, integer division, DIV >= 2.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 CLK  input  1  sole clock, all logic on its rising edge.
REQ-008 RESET  input  1  asynchronous, active-low reset.
REQ-009 PROBE  input  WIDTH  monitored bus, synchronous to CLK.
REQ-010 TXD  output  1  UART 8N1 serial record stream, idle high.
REQ-011 OVERFLOW  output  1  sticky flag: at least one record was dropped.
REQ-012 BUSY  output  1  high while the FIFO is non-empty or a frame is in progress.

Function
REQ-013 PROBE SHALL be registered into sample S each cycle; previous-value register P SHALL reset to 0.
REQ-014 When S != P at edge n+1 (PROBE changed before edge n), a record {timestamp, S} SHALL be pushed at edge n+1 and P <= S.
REQ-015 The timestamp SHALL be a free-running TS_WIDTH counter: reset 0, +1 every cycle, wraps modulo 2^TS_WIDTH with no marker; the record carries its value at the push edge.
REQ-016 Every change SHALL produce its own record, including 1-cycle glitches; no coalescing.
REQ-017 Push SHALL be evaluated against occupancy before any same-cycle pop; a push into a full FIFO SHALL drop the record and set OVERFLOW, even if a pop occurs that cycle.
REQ-018 OVERFLOW SHALL stay high until reset.
REQ-019 The serializer SHALL be a state machine IDLE -> LOAD -> SEND(byte k) -> IDLE; in IDLE with FIFO non-empty it SHALL pop at the next edge. A push into an empty FIFO SHALL NOT be popped in the same cycle.
REQ-020 A frame SHALL be 0xA5, then TS_WIDTH/8 timestamp bytes MSB-first, then ceil(WIDTH/8) value bytes MSB-first, zero-padded above WIDTH.
REQ-021 Each byte SHALL be start bit 0, 8 data bits LSB-first, 1 stop bit; each bit SHALL last exactly DIV cycles; consecutive bytes and frames SHALL be back-to-back, with no idle bits.
REQ-022 After the push into an empty FIFO with the serializer idle, the start bit SHALL appear on TXD at edge n+3, where the push was at edge n+1.

Reset
REQ-023 When RESET is low: TXD=1, OVERFLOW=0, BUSY=0, the FIFO is emptied, S=P=0, the timestamp is 0, and the serializer is in IDLE; this applies immediately, including mid-frame.
REQ-024 After reset release, a non-zero PROBE SHALL produce a record, because P=0.

Configuration
REQ-025 Macro CHANGE_LOGGER_TIMESTAMP_EN SHALL control timestamps.
REQ-026 With CHANGE_LOGGER_TIMESTAMP_EN defined: the counter is present and frames follow REQ-020.
REQ-027 Without CHANGE_LOGGER_TIMESTAMP_EN: no counter and no timestamp FIFO bits; a frame is 0xA5 followed by the value bytes only.

Structure
REQ-028 Shared package trace_pkg SHALL hold: the header constant 0xA5, a bytes-per-width function ceil(w/8), and the serializer state encoding.
REQ-029 Sub-module uart_tx (byte in, valid/ready handshake, DIV parameter, TXD out) SHALL be instantiated once.
REQ-030 The FIFO and change detector SHALL be inline.

Verification (all with DIV=4, macro defined unless noted)
REQ-031 Reset: hold PROBE=0 -> TXD=1, BUSY=0, OVERFLOW=0, no start bit for 1000 cycles.
REQ-032 PROBE 0x00->0x01 with timestamp 0x0123 at the push edge -> frame A5 01 23 01, start bit at push+2 cycles, 40 cycles per byte.
REQ-033 PROBE 0x00->0x03 for 1 cycle, then back to 0x00 -> two frames, values 03 then 00, timestamps differing by 1.
REQ-034 DEPTH=4, 7 changes on consecutive cycles -> exactly 5 frames in order, OVERFLOW=1 from the 6th push edge.
REQ-035 RESET low during the 2nd byte with PROBE=0x5A -> TXD=1 immediately, OVERFLOW=0; after release one frame with value 5A and timestamp 1.
REQ-036 Macro undefined, WIDTH=12, PROBE 0x000->0xABC -> frame A5 0A BC.
